// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, Prescale-times oversampling with 3-sample majority,
// optional even/odd parity, registered one-cycle Data_Valid / Par_Err / Stop_Err strobes.
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      Par_En,
  input  logic                      Par_Typ,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      Data_Valid,
  output logic                      Par_Err,
  output logic                      Stop_Err,
  output logic                      Busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic [1:0]                sync_r;
  logic                      rx_s;
  state_t                    state_r, next_state_s;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_r;
  logic [PRESCALE_WIDTH-1:0] half_s;
  logic [BIT_W-1:0]          bit_cnt_r;
  logic [2:0]                samples_r;
  logic [DATA_WIDTH-1:0]     shift_r;
  logic                      par_en_r, par_typ_r, par_mismatch_r;
  logic [DATA_WIDTH-1:0]     p_data_r;
  logic                      data_valid_r, par_err_r, stop_err_r, busy_r;
  logic                      last_s, check_s, maj_s;
  logic                      start_frame_s, shift_en_s, par_check_s, finish_s;

  assign rx_s    = sync_r[1];
  assign half_s  = Prescale >> 1;
  // Counter compares wrap modulo 2^PRESCALE_WIDTH, so illegal Prescale values still terminate.
  assign last_s  = (edge_cnt_r == (Prescale - PRESCALE_WIDTH'(1)));
  assign check_s = (edge_cnt_r == (half_s + PRESCALE_WIDTH'(2)));
  assign maj_s   = majority3(samples_r);

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_r <= 2'b11;
    else        sync_r <= {sync_r[0], RX_IN};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic and per-bit datapath enables.
  always_comb begin
    next_state_s  = state_r;
    start_frame_s = 1'b0;
    shift_en_s    = 1'b0;
    par_check_s   = 1'b0;
    finish_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          next_state_s  = START;
          start_frame_s = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        if (check_s && maj_s)  next_state_s = IDLE;
        else if (last_s)       next_state_s = DATA;
        else                   next_state_s = START;
      end
      DATA: begin
        if (last_s) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == LAST_BIT) next_state_s = par_en_r ? PARITY : STOP;
          else                       next_state_s = DATA;
        end else begin
          next_state_s = DATA;
        end
      end
      PARITY: begin
        if (last_s) begin
          par_check_s  = 1'b1;
          next_state_s = STOP;
        end else begin
          next_state_s = PARITY;
        end
      end
      STOP: begin
        if (last_s) begin
          finish_s     = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = STOP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Capture the three mid-bit samples used for majority voting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        samples_r    <= 3'b000;
    else if (edge_cnt_r == (half_s - PRESCALE_WIDTH'(1))) samples_r[0] <= rx_s;
    else if (edge_cnt_r == half_s)                     samples_r[1] <= rx_s;
    else if (edge_cnt_r == (half_s + PRESCALE_WIDTH'(1))) samples_r[2] <= rx_s;
  end

  // Counters, shift register, frame settings and registered output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_r     <= {PRESCALE_WIDTH{1'b0}};
      bit_cnt_r      <= {BIT_W{1'b0}};
      shift_r        <= {DATA_WIDTH{1'b0}};
      par_en_r       <= 1'b0;
      par_typ_r      <= 1'b0;
      par_mismatch_r <= 1'b0;
      p_data_r       <= {DATA_WIDTH{1'b0}};
      data_valid_r   <= 1'b0;
      par_err_r      <= 1'b0;
      stop_err_r     <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      par_err_r    <= 1'b0;
      stop_err_r   <= 1'b0;
      busy_r       <= (next_state_s != IDLE);
      if (next_state_s == IDLE)  edge_cnt_r <= {PRESCALE_WIDTH{1'b0}};
      else if (state_r == IDLE)  edge_cnt_r <= PRESCALE_WIDTH'(1);
      else if (last_s)           edge_cnt_r <= {PRESCALE_WIDTH{1'b0}};
      else                       edge_cnt_r <= edge_cnt_r + PRESCALE_WIDTH'(1);
      if (start_frame_s) begin
        bit_cnt_r      <= {BIT_W{1'b0}};
        par_en_r       <= Par_En;
        par_typ_r      <= Par_Typ;
        par_mismatch_r <= 1'b0;
      end
      if (shift_en_s) begin
        shift_r   <= {maj_s, shift_r[DATA_WIDTH-1:1]};
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end
      if (par_check_s) par_mismatch_r <= (maj_s != parity_of(shift_r, par_typ_r));
      if (finish_s) begin
        stop_err_r <= ~maj_s;
        par_err_r  <= par_mismatch_r;
        if (maj_s && !par_mismatch_r) begin
          p_data_r     <= shift_r;
          data_valid_r <= 1'b1;
        end
      end
    end
  end

  assign P_DATA     = p_data_r;
  assign Data_Valid = data_valid_r;
  assign Par_Err    = par_err_r;
  assign Stop_Err   = stop_err_r;
  assign Busy       = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames checked against
// a frame-level model (decoded fields, parity by popcount, latency B*Prescale+1).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       Par_En, Par_Typ;
  logic [7:0] P_DATA;
  logic       Data_Valid, Par_Err, Stop_Err, Busy;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .RX_IN(RX_IN), .Prescale(Prescale),
    .Par_En(Par_En), .Par_Typ(Par_Typ), .P_DATA(P_DATA),
    .Data_Valid(Data_Valid), .Par_Err(Par_Err), .Stop_Err(Stop_Err), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
  } ev_t;
  ev_t evq[$];

  // Record every strobe cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (Data_Valid || Par_Err || Stop_Err)) begin
      ev_t e;
      e.cyc = cyc; e.dv = Data_Valid; e.pe = Par_Err; e.se = Stop_Err; e.data = P_DATA;
      evq.push_back(e);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drive one frame; cycle j of the frame is line bit j/p, optionally inverted at noise_j.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic sbit, input int p, input int noise_j, output int e0);
    logic [10:0] bits;
    int nb;
    bits = 11'h7FF;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (pen) begin bits[9] = pbit; bits[10] = sbit; nb = 11; end
    else     begin bits[9] = sbit; nb = 10; end
    e0 = cyc + 1;
    for (int j = 0; j < nb * p; j++) begin
      RX_IN = bits[j / p] ^ (j == noise_j);
      tick(1);
    end
    RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; Par_En = 1'b0; Par_Typ = 1'b0;
    tick(3);
    checks++;
    if ({P_DATA, Data_Valid, Par_Err, Stop_Err, Busy} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 000", {P_DATA, Data_Valid, Par_Err, Stop_Err, Busy});
    end
    rst_n = 1'b1;
    tick(6);
    checks++;
    if (Busy !== 1'b0 || evq.size() != 0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b events=%0d expected busy=0 events=0", Busy, evq.size());
    end
  endtask

  task automatic test_basic();
    int e0; ev_t ev;
    evq.delete(); Prescale = 6'd8; Par_En = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8, -1, e0);
    tick(4);
    checks++;
    if (evq.size() != 1) begin
      failures++; $display("FAIL basic_count: got %0d events expected 1", evq.size());
    end else begin
      ev = evq.pop_front();
      checks++;
      if (ev.cyc !== e0 + 81) begin
        failures++; $display("FAIL basic_latency: got edge %0d expected %0d", ev.cyc - e0, 81);
      end
      checks++;
      if ({ev.dv, ev.pe, ev.se, ev.data} !== {3'b100, 8'hA5}) begin
        failures++; $display("FAIL basic_strobe: got dv/pe/se=%b%b%b data=%h expected 100 a5", ev.dv, ev.pe, ev.se, ev.data);
      end
    end
    checks++;
    if (P_DATA !== 8'hA5 || Busy !== 1'b0) begin
      failures++; $display("FAIL basic_hold: got data=%h busy=%b expected a5 0", P_DATA, Busy);
    end
  endtask

  task automatic test_parity();
    int e0; ev_t ev;
    evq.delete(); Prescale = 6'd16; Par_En = 1'b1; Par_Typ = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16, -1, e0);
    tick(4);
    checks++;
    if (evq.size() != 1) begin
      failures++; $display("FAIL even_ok_count: got %0d events expected 1", evq.size());
    end else begin
      ev = evq.pop_front();
      checks++;
      if (ev.cyc !== e0 + 177 || {ev.dv, ev.pe, ev.se, ev.data} !== {3'b100, 8'h3C}) begin
        failures++; $display("FAIL even_ok: got edge %0d dv/pe/se=%b%b%b data=%h expected 177 100 3c", ev.cyc - e0, ev.dv, ev.pe, ev.se, ev.data);
      end
    end
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16, -1, e0);
    tick(4);
    checks++;
    if (evq.size() != 1) begin
      failures++; $display("FAIL even_bad_count: got %0d events expected 1", evq.size());
    end else begin
      ev = evq.pop_front();
      checks++;
      if (ev.cyc !== e0 + 177 || {ev.dv, ev.pe, ev.se} !== 3'b010) begin
        failures++; $display("FAIL even_bad: got edge %0d dv/pe/se=%b%b%b expected 177 010", ev.cyc - e0, ev.dv, ev.pe, ev.se);
      end
    end
    checks++;
    if (P_DATA !== 8'h3C) begin
      failures++; $display("FAIL even_bad_hold: got %h expected 3c", P_DATA);
    end
  endtask

  task automatic test_stop();
    int e0; ev_t ev;
    evq.delete(); Prescale = 6'd32; Par_En = 1'b1; Par_Typ = 1'b1;
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 32, -1, e0);
    tick(4);
    checks++;
    if (evq.size() != 1) begin
      failures++; $display("FAIL odd_ok_count: got %0d events expected 1", evq.size());
    end else begin
      ev = evq.pop_front();
      checks++;
      if (ev.cyc !== e0 + 353 || {ev.dv, ev.pe, ev.se, ev.data} !== {3'b100, 8'hFF}) begin
        failures++; $display("FAIL odd_ok: got edge %0d dv/pe/se=%b%b%b data=%h expected 353 100 ff", ev.cyc - e0, ev.dv, ev.pe, ev.se, ev.data);
      end
    end
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 32, -1, e0);
    tick(4);
    checks++;
    if (evq.size() != 1) begin
      failures++; $display("FAIL stop_err_count: got %0d events expected 1", evq.size());
    end else begin
      ev = evq.pop_front();
      checks++;
      if ({ev.dv, ev.pe, ev.se} !== 3'b001 || P_DATA !== 8'hFF) begin
        failures++; $display("FAIL stop_err: got dv/pe/se=%b%b%b data=%h expected 001 ff", ev.dv, ev.pe, ev.se, P_DATA);
      end
    end
  endtask

  task automatic test_glitch();
    logic saw_busy;
    evq.delete(); Prescale = 6'd8; Par_En = 1'b0;
    RX_IN = 1'b0;
    tick(3);
    RX_IN = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (Busy === 1'b1) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b1 || Busy !== 1'b0) begin
      failures++; $display("FAIL glitch_busy: got saw_busy=%b busy=%b expected 1 0", saw_busy, Busy);
    end
    tick(20);
    checks++;
    if (evq.size() != 0) begin
      failures++; $display("FAIL glitch_strobe: got %0d events expected 0", evq.size());
    end
  endtask

  task automatic test_noise();
    int e0; ev_t ev;
    evq.delete(); Prescale = 6'd8; Par_En = 1'b0;
    // frame cycle 28 = line bit 3 (data bit 2), middle sample
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 8, 28, e0);
    tick(4);
    checks++;
    if (evq.size() != 1) begin
      failures++; $display("FAIL noise_count: got %0d events expected 1", evq.size());
    end else begin
      ev = evq.pop_front();
      checks++;
      if ({ev.dv, ev.pe, ev.se, ev.data} !== {3'b100, 8'h00}) begin
        failures++; $display("FAIL noise_data: got dv/pe/se=%b%b%b data=%h expected 100 00", ev.dv, ev.pe, ev.se, ev.data);
      end
    end
  endtask

  task automatic test_random();
    int e0, p, nb, noise_j, ones;
    logic [7:0] d, model_data;
    logic pen, typ, pbit, pbit_ok, sbit, exp_dv, exp_pe, exp_se;
    ev_t ev;
    model_data = P_DATA === 8'h00 ? 8'h00 : 8'h00;
    for (int i = 0; i < 10; i++) begin
      evq.delete();
      p = 8 << $urandom_range(0, 2);
      pen = 1'($urandom_range(0, 1));
      typ = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      ones = $countones(d);
      pbit_ok = 1'(ones % 2) ^ typ;
      pbit = ($urandom_range(0, 3) == 0) ? ~pbit_ok : pbit_ok;
      sbit = ($urandom_range(0, 4) != 0);
      nb = pen ? 11 : 10;
      noise_j = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, nb * p - 1)) : -1;
      exp_pe = pen && (pbit != pbit_ok);
      exp_se = ~sbit;
      exp_dv = !exp_pe && !exp_se;
      if (exp_dv) model_data = d;
      Prescale = 6'(p); Par_En = pen; Par_Typ = typ;
      send_frame(d, pen, pbit, sbit, p, noise_j, e0);
      tick(4);
      checks++;
      if (evq.size() != 1) begin
        failures++; $display("FAIL rand_count[%0d]: got %0d events expected 1", i, evq.size());
      end else begin
        ev = evq.pop_front();
        checks++;
        if (ev.cyc !== e0 + nb * p + 1) begin
          failures++; $display("FAIL rand_latency[%0d]: got edge %0d expected %0d", i, ev.cyc - e0, nb * p + 1);
        end
        checks++;
        if ({ev.dv, ev.pe, ev.se} !== {exp_dv, exp_pe, exp_se}) begin
          failures++; $display("FAIL rand_flags[%0d]: got dv/pe/se=%b%b%b expected %b%b%b", i, ev.dv, ev.pe, ev.se, exp_dv, exp_pe, exp_se);
        end
      end
      checks++;
      if (P_DATA !== model_data || Busy !== 1'b0) begin
        failures++; $display("FAIL rand_data[%0d]: got data=%h busy=%b expected %h 0", i, P_DATA, Busy, model_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e0a, e0b; ev_t ev0, ev1;
    evq.delete(); Prescale = 6'd8; Par_En = 1'b0;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 8, -1, e0a);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, 8, -1, e0b);
    tick(4);
    checks++;
    if (evq.size() != 2) begin
      failures++; $display("FAIL b2b_count: got %0d events expected 2", evq.size());
    end else begin
      ev0 = evq.pop_front();
      ev1 = evq.pop_front();
      checks++;
      if (ev0.cyc !== e0a + 81 || ev1.cyc - ev0.cyc !== 80) begin
        failures++; $display("FAIL b2b_timing: got first %0d gap %0d expected 81 80", ev0.cyc - e0a, ev1.cyc - ev0.cyc);
      end
      checks++;
      if ({ev0.dv, ev0.data, ev1.dv, ev1.data} !== {1'b1, 8'h12, 1'b1, 8'h34}) begin
        failures++; $display("FAIL b2b_data: got %b %h %b %h expected 1 12 1 34", ev0.dv, ev0.data, ev1.dv, ev1.data);
      end
    end
    RX_IN = 1'b0;
    tick(24);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({P_DATA, Data_Valid, Par_Err, Stop_Err, Busy} !== 12'h000) begin
      failures++; $display("FAIL midframe_reset: got %h expected 000", {P_DATA, Data_Valid, Par_Err, Stop_Err, Busy});
    end
    RX_IN = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(120);
    checks++;
    if (evq.size() != 0 || Busy !== 1'b0 || P_DATA !== 8'h00) begin
      failures++; $display("FAIL post_reset_quiet: got events=%0d busy=%b data=%h expected 0 0 00", evq.size(), Busy, P_DATA);
    end
  endtask

  initial begin
    rst_n = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; Par_En = 1'b0; Par_Typ = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_parity();
    test_stop();
    test_glitch();
    test_noise();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
